// File: rtl/bcd_conv_pkg.sv
// Shared types and constants for the binary-to-BCD result converter.
package bcd_conv_pkg;

  localparam int DIGIT_W      = 4;
  localparam int IN_WIDTH_DEF = 16;
  localparam int DIGITS_DEF   = 5;
  localparam int CNT_W        = $clog2(IN_WIDTH_DEF);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  // Counter width for an arbitrary operand width (at least one bit).
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // True when 10^digits > 2^in_width, i.e. every operand value fits.
  function automatic bit digits_fit(input int in_width, input int digits);
    longint unsigned p10;
    longint unsigned limit;
    p10   = 1;
    limit = 64'd1 << in_width;
    for (int i = 0; i < digits; i++) begin
      if (p10 > limit) return 1'b1;
      p10 = p10 * 10;
    end
    return p10 > limit;
  endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// Double-dabble correction cell: a digit of 5 or more gets +3 before the shift.
module bcd_digit_adjust
  import bcd_conv_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit,
  output logic [DIGIT_W-1:0] adjusted
);

  assign adjusted = (digit >= DIGIT_W'(5)) ? digit + DIGIT_W'(3) : digit;

endmodule

// File: rtl/bcd_result_converter.sv
// Sequential binary-to-BCD converter (shift/add-3) with optional sign handling.
module bcd_result_converter
  import bcd_conv_pkg::*;
#(
  parameter int IN_WIDTH = IN_WIDTH_DEF,
  parameter int DIGITS   = DIGITS_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  signed_in,
  input  logic [IN_WIDTH-1:0]   bin,
  output logic                  busy,
  output logic                  done,
  output logic                  negative,
  output logic [DIGIT_W*DIGITS-1:0] bcd
);

  localparam int CW    = cnt_width(IN_WIDTH);
  localparam int BCD_W = DIGIT_W * DIGITS;

  if (!digits_fit(IN_WIDTH, DIGITS)) begin : g_bad_digits
    $error("bcd_result_converter: DIGITS too small for IN_WIDTH");
  end

  state_t              state;
  state_t              state_next;
  logic [IN_WIDTH-1:0] mag;
  logic [BCD_W-1:0]    scratch;
  logic [BCD_W-1:0]    adjusted;
  logic [BCD_W-1:0]    shifted;
  logic [CW-1:0]       count;
  logic                neg_pending;
  logic                last_shift;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adjust
    bcd_digit_adjust u_adjust (
      .digit    (scratch[g*DIGIT_W +: DIGIT_W]),
      .adjusted (adjusted[g*DIGIT_W +: DIGIT_W])
    );
  end

  assign shifted    = {adjusted[BCD_W-2:0], mag[IN_WIDTH-1]};
  assign last_shift = (count == CW'(IN_WIDTH - 1));
  assign busy       = (state == SHIFT);
  assign done       = (state == DONE);

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic; IDLE accepts start, SHIFT runs IN_WIDTH cycles, DONE lasts one cycle.
  // NOTE: state_next is defaulted first so no path leaves it unassigned (no latch).
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = SHIFT;
      SHIFT:   if (last_shift) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: operand capture, shift/add-3 iterations and result publication.
  always_ff @(posedge clk) begin
    if (reset) begin
      mag         <= '0;
      scratch     <= '0;
      count       <= '0;
      neg_pending <= 1'b0;
      bcd         <= '0;
      negative    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            // -bin of the most-negative value is itself, read as unsigned magnitude.
            mag         <= (signed_in && bin[IN_WIDTH-1]) ? -bin : bin;
            neg_pending <= signed_in && bin[IN_WIDTH-1];
            scratch     <= '0;
            count       <= '0;
          end
        end
        SHIFT: begin
          scratch <= shifted;
          mag     <= mag << 1;
          count   <= count + CW'(1);
          // Publish on the final shift so bcd/negative are valid while done is high.
          if (last_shift) begin
            bcd      <= shifted;
            negative <= neg_pending;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_result_converter.sv
// Directed self-checking bench for bcd_result_converter.
module tb_bcd_result_converter;

  logic        clk;
  logic        reset;
  logic        start;
  logic        signed_in;
  logic [15:0] bin;
  logic        busy;
  logic        done;
  logic        negative;
  logic [19:0] bcd;

  int vectors;
  int miscompares;
  int cyc;
  int done_cnt;

  bcd_result_converter dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .signed_in (signed_in),
    .bin       (bin),
    .busy      (busy),
    .done      (done),
    .negative  (negative),
    .bcd       (bcd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;
  always @(negedge clk) if (done === 1'b1) done_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Wait (bounded) for a done pulse; returns cycles waited and whether seen.
  task automatic wait_done(input int limit, output bit seen, output int lat, output int busy_cycles);
    seen        = 1'b0;
    lat         = 0;
    busy_cycles = 0;
    for (int i = 0; i < limit && !seen; i++) begin
      @(negedge clk);
      lat = i + 1;
      if (done === 1'b1) seen = 1'b1;
      else if (busy === 1'b1) busy_cycles++;
    end
  endtask

  // Full conversion with latency, busy-length, result and pulse-width checks.
  task automatic convert(input string tag, input logic sgn, input logic [15:0] value,
                         input logic [19:0] exp_bcd, input logic exp_neg);
    bit seen;
    int lat;
    int busy_cycles;
    @(negedge clk);
    start     = 1'b1;
    signed_in = sgn;
    bin       = value;
    @(posedge clk);
    #1;
    start     = 1'b0;
    signed_in = ~sgn;
    bin       = 16'hDEAD;
    wait_done(40, seen, lat, busy_cycles);
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    check({tag, "_latency"}, 32'(lat), 32'd17);
    check({tag, "_busy_cycles"}, 32'(busy_cycles), 32'd16);
    check({tag, "_bcd"}, 32'(bcd), 32'(exp_bcd));
    check({tag, "_negative"}, 32'(negative), 32'(exp_neg));
    @(negedge clk);
    check({tag, "_done_width"}, 32'(done), 32'd0);
  endtask

  initial begin
    bit seen;
    int lat;
    int busy_cycles;
    int base;
    int stamps[$];

    vectors     = 0;
    miscompares = 0;
    cyc         = 0;
    done_cnt    = 0;
    reset       = 1'b1;
    start       = 1'b0;
    signed_in   = 1'b0;
    bin         = 16'h0000;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_bcd", 32'(bcd), 32'd0);
    check("rst_negative", 32'(negative), 32'd0);
    reset = 1'b0;

    convert("u_ff", 1'b0, 16'h00FF, 20'h00255, 1'b0);
    convert("u_max", 1'b0, 16'hFFFF, 20'h65535, 1'b0);

    // Result holds while idle and while a new conversion is in progress.
    repeat (5) @(negedge clk);
    check("hold_idle_bcd", 32'(bcd), 32'h65535);
    start = 1'b1;
    bin   = 16'h0001;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (8) @(negedge clk);
    check("hold_busy", 32'(busy), 32'd1);
    check("hold_busy_bcd", 32'(bcd), 32'h65535);
    wait_done(20, seen, lat, busy_cycles);
    check("hold_done_seen", 32'(seen), 32'd1);
    check("hold_new_bcd", 32'(bcd), 32'h00001);

    convert("s_m1", 1'b1, 16'hFFFF, 20'h00001, 1'b1);
    convert("s_min", 1'b1, 16'h8000, 20'h32768, 1'b1);
    convert("s_zero", 1'b1, 16'h0000, 20'h00000, 1'b0);
    convert("s_pos", 1'b1, 16'h3039, 20'h12345, 1'b0);

    // Start during SHIFT is ignored and not queued.
    @(negedge clk);
    base      = done_cnt;
    start     = 1'b1;
    signed_in = 1'b0;
    bin       = 16'h0007;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(negedge clk);
    start = 1'b1;
    bin   = 16'h1234;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (40) @(negedge clk);
    check("ign_done_count", 32'(done_cnt - base), 32'd1);
    check("ign_bcd", 32'(bcd), 32'h00007);
    check("ign_idle", 32'(busy), 32'd0);

    // Start held high: back-to-back conversions every 18 cycles.
    @(negedge clk);
    start     = 1'b1;
    signed_in = 1'b0;
    bin       = 16'd42;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (done === 1'b1) stamps.push_back(cyc);
    end
    start = 1'b0;
    repeat (20) @(negedge clk);
    check("held_count_ge3", 32'(stamps.size() >= 3), 32'd1);
    if (stamps.size() >= 3) begin
      check("held_gap1", 32'(stamps[1] - stamps[0]), 32'd18);
      check("held_gap2", 32'(stamps[2] - stamps[1]), 32'd18);
    end
    check("held_bcd", 32'(bcd), 32'h00042);

    // Reset mid-conversion abandons it without a done pulse.
    convert("pre_rst", 1'b1, 16'hFFFF, 20'h00001, 1'b1);
    @(negedge clk);
    start     = 1'b1;
    signed_in = 1'b0;
    bin       = 16'h3039;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (7) @(negedge clk);
    base  = done_cnt;
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_bcd", 32'(bcd), 32'd0);
    check("mid_rst_negative", 32'(negative), 32'd0);
    reset = 1'b0;
    repeat (25) @(negedge clk);
    check("mid_rst_no_done", 32'(done_cnt - base), 32'd0);
    convert("post_rst", 1'b0, 16'h3039, 20'h12345, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
